sync_to_blanking_gen: RTL and testbench
=======================================

# sync_to_blanking_gen

Derives horizontal and vertical blanking strobes from a bare pair of active-low sync pulses, such as those produced by the VGA sync pulse generator. It measures line length, frame height and sync widths on the fly, then applies fixed front/back porch parameters. It sits between the output-side sync generator and consumers that need blanking, such as the upscaler and loggers. Sync is re-emitted with the same latency as the derived blanking so the two stay aligned.

## Interface
Parameters:
- H_FRONT_PORCH, 16, pixel clocks of blanking before the hsync falling edge
- H_BACK_PORCH, 48, pixel clocks of blanking after the hsync rising edge
- V_FRONT_PORCH, 10, lines of blanking before the vsync falling edge
- V_BACK_PORCH, 33, lines of blanking after the vsync rising edge
- COUNTER_WIDTH, 12, width of all position, length and width counters

Ports:
- i_Clk  in  1  pixel clock; the only clock
- i_Rst  in  1  reset, synchronous, active-high
- i_nHSync  in  1  active-low horizontal sync, synchronous to i_Clk
- i_nVSync  in  1  active-low vertical sync, synchronous to i_Clk
- o_nHSync  out  1  i_nHSync delayed one clock
- o_nVSync  out  1  i_nVSync delayed one clock
- o_HBlank  out  1  active-high horizontal blanking
- o_VBlank  out  1  active-high vertical blanking

## Operation
- Edge detection compares each input against its previous-clock sample. The previous-sample registers reset to 1.
- Horizontal pixel index p:
  - p = 0 on the sample where the hsync falling edge is detected.
  - p otherwise increments by 1 per clock and saturates at 2^COUNTER_WIDTH−1.
- On each hsync fall, the line length is latched: L = p of the preceding sample + 1.
- On the first high sample after a fall (rise), the sync width is latched: W = p.
- h_locked sets once a rise and then a second fall have been seen. It clears only on reset.
- Horizontal blank for sample p:
  - o_HBlank = 1 if !h_locked, or p < W + H_BACK_PORCH, or p + H_FRONT_PORCH ≥ L.
  - Comparisons use COUNTER_WIDTH+1 bits, so there is no wrap or underflow.
  - If the porches plus W cover the whole line, the entire line is blanked.
- Vertical line index v:
  - v = 0 on the sample where the vsync falling edge is detected.
  - v otherwise increments on every hsync fall that is not coincident with a vsync fall, and saturates.
- Frame height: T = v + 1, latched at the vsync fall.
- Vsync width: VW = v, latched on the vsync rise.
- v_locked sets after a vsync rise followed by a second vsync fall. It clears only on reset.
- Vertical blank:
  - o_VBlank = 1 if !v_locked, or v < VW + V_BACK_PORCH, or v + V_FRONT_PORCH ≥ T.
- Latched lengths and widths update every line and frame. New values take effect from the sample that latches them.

## Timing
- All outputs are registered. Each output reflects the input sample from the previous clock: one-clock latency, with sync and blank on the same cycle.
- Reset values:
  - o_nHSync = 1, o_nVSync = 1, o_HBlank = 1, o_VBlank = 1
  - p, v, L, W, T and VW = 0
  - h_locked = 0, v_locked = 0
- Reset asserted mid-frame returns all of the above to reset values on the next clock. Lock is then reacquired from scratch.
- Simultaneous hsync and vsync falls: v = 0 and p = 0 in the same sample.
- Saturated counters hold their value. A line longer than 2^COUNTER_WIDTH−1 clocks keeps o_HBlank from asserting the front porch only through the saturating compare; this is not an error condition.

## Test plan
- Reset: hold i_Rst for 5 clocks with any inputs -> o_nHSync = o_nVSync = 1 and o_HBlank = o_VBlank = 1 throughout and one clock after.
- Pass-through: toggle i_nHSync and i_nVSync -> o_nHSync and o_nVSync equal the inputs delayed exactly one clock.
- VGA horizontal, 800-clock line with 96-clock hsync, after lock:
  - o_HBlank = 0 for exactly 640 clocks per line, for samples p = 144..783.
  - o_HBlank = 1 for p = 0..143 and p = 784..799.
- VGA vertical, 525-line frame with 2-line vsync, after two vsyncs:
  - o_VBlank = 0 for lines v = 35..514, which is 480 lines.
  - o_VBlank = 1 elsewhere.
  - o_VBlank = 1 for the whole first frame.
- Length change: switch to a 1000-clock line -> from the next line, o_HBlank deasserts at p = 144 and reasserts at p = 984.
- Mid-frame reset: assert i_Rst for 1 clock during active video -> all blanks read 1 until relock, which takes one full line for H and two vsync falls for V.

Source files
------------

// File: rtl/sync_to_blanking_gen.sv
// sync_to_blanking_gen
// Derives horizontal/vertical blanking from bare active-low sync pulses.
// Line length, frame height and sync widths are measured on the fly; fixed
// front/back porches are then applied around the sync pulses. Sync is
// re-emitted with the same one-clock latency as the derived blanking.
//
// Ports:
//   i_Clk     pixel clock
//   i_Rst     synchronous active-high reset
//   i_nHSync  active-low horizontal sync in
//   i_nVSync  active-low vertical sync in
//   o_nHSync  i_nHSync delayed one clock
//   o_nVSync  i_nVSync delayed one clock
//   o_HBlank  active-high horizontal blanking
//   o_VBlank  active-high vertical blanking
module sync_to_blanking_gen #(
  parameter int unsigned H_FRONT_PORCH = 16,
  parameter int unsigned H_BACK_PORCH  = 48,
  parameter int unsigned V_FRONT_PORCH = 10,
  parameter int unsigned V_BACK_PORCH  = 33,
  parameter int unsigned COUNTER_WIDTH = 12
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_nHSync,
  input  logic i_nVSync,
  output logic o_nHSync,
  output logic o_nVSync,
  output logic o_HBlank,
  output logic o_VBlank
);

  localparam int unsigned CW = COUNTER_WIDTH;
  // Lengths are count+1 and compares need headroom, so they use one extra bit.
  localparam int unsigned XW = COUNTER_WIDTH + 1;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [XW-1:0] H_FP_X  = XW'(H_FRONT_PORCH);
  localparam logic [XW-1:0] H_BP_X  = XW'(H_BACK_PORCH);
  localparam logic [XW-1:0] V_FP_X  = XW'(V_FRONT_PORCH);
  localparam logic [XW-1:0] V_BP_X  = XW'(V_BACK_PORCH);

  // Previous-sample registers for edge detection
  logic          h_prev_q, h_prev_d;
  logic          v_prev_q, v_prev_d;

  // Horizontal measurement
  logic [CW-1:0] p_q, p_d;
  logic [XW-1:0] l_q, l_d;
  logic [CW-1:0] w_q, w_d;
  logic          h_rise_seen_q, h_rise_seen_d;
  logic          h_locked_q, h_locked_d;

  // Vertical measurement
  logic [CW-1:0] v_q, v_d;
  logic [XW-1:0] t_q, t_d;
  logic [CW-1:0] vw_q, vw_d;
  logic          v_rise_seen_q, v_rise_seen_d;
  logic          v_locked_q, v_locked_d;

  // Registered outputs
  logic          nhsync_q, nhsync_d;
  logic          nvsync_q, nvsync_d;
  logic          hblank_q, hblank_d;
  logic          vblank_q, vblank_d;

  logic          h_fall, h_rise, v_fall, v_rise;

  // Next-state: counters, latched measurements, lock and blanking decision
  always_comb begin
    h_fall        = 1'b0;
    h_rise        = 1'b0;
    v_fall        = 1'b0;
    v_rise        = 1'b0;
    h_prev_d      = i_nHSync;
    v_prev_d      = i_nVSync;
    p_d           = p_q;
    l_d           = l_q;
    w_d           = w_q;
    h_rise_seen_d = h_rise_seen_q;
    h_locked_d    = h_locked_q;
    v_d           = v_q;
    t_d           = t_q;
    vw_d          = vw_q;
    v_rise_seen_d = v_rise_seen_q;
    v_locked_d    = v_locked_q;
    nhsync_d      = i_nHSync;
    nvsync_d      = i_nVSync;

    h_fall = h_prev_q & ~i_nHSync;
    h_rise = ~h_prev_q & i_nHSync;
    v_fall = v_prev_q & ~i_nVSync;
    v_rise = ~v_prev_q & i_nVSync;

    // Pixel index restarts at the hsync fall, otherwise saturates upward
    if (h_fall) begin
      p_d = '0;
    end else if (p_q != CNT_MAX) begin
      p_d = p_q + CW'(1);
    end

    if (h_fall) begin
      l_d = {1'b0, p_q} + XW'(1);
    end
    if (h_rise) begin
      w_d           = p_d;
      h_rise_seen_d = 1'b1;
    end
    // A rise always follows some fall, so a fall after a rise means a full line
    if (h_fall && h_rise_seen_q) begin
      h_locked_d = 1'b1;
    end

    // Line index counts hsync falls; the vsync fall takes precedence
    if (v_fall) begin
      v_d = '0;
    end else if (h_fall && (v_q != CNT_MAX)) begin
      v_d = v_q + CW'(1);
    end

    if (v_fall) begin
      t_d = {1'b0, v_q} + XW'(1);
    end
    if (v_rise) begin
      vw_d          = v_d;
      v_rise_seen_d = 1'b1;
    end
    if (v_fall && v_rise_seen_q) begin
      v_locked_d = 1'b1;
    end

    // Freshly latched values apply to the sample that latched them
    hblank_d = ~h_locked_d
             | ({1'b0, p_d} < ({1'b0, w_d} + H_BP_X))
             | (({1'b0, p_d} + H_FP_X) >= l_d);
    vblank_d = ~v_locked_d
             | ({1'b0, v_d} < ({1'b0, vw_d} + V_BP_X))
             | (({1'b0, v_d} + V_FP_X) >= t_d);
  end

  // State and output registers
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      h_prev_q      <= 1'b1;
      v_prev_q      <= 1'b1;
      p_q           <= '0;
      l_q           <= '0;
      w_q           <= '0;
      h_rise_seen_q <= 1'b0;
      h_locked_q    <= 1'b0;
      v_q           <= '0;
      t_q           <= '0;
      vw_q          <= '0;
      v_rise_seen_q <= 1'b0;
      v_locked_q    <= 1'b0;
      nhsync_q      <= 1'b1;
      nvsync_q      <= 1'b1;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
    end else begin
      h_prev_q      <= h_prev_d;
      v_prev_q      <= v_prev_d;
      p_q           <= p_d;
      l_q           <= l_d;
      w_q           <= w_d;
      h_rise_seen_q <= h_rise_seen_d;
      h_locked_q    <= h_locked_d;
      v_q           <= v_d;
      t_q           <= t_d;
      vw_q          <= vw_d;
      v_rise_seen_q <= v_rise_seen_d;
      v_locked_q    <= v_locked_d;
      nhsync_q      <= nhsync_d;
      nvsync_q      <= nvsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
    end
  end

  assign o_nHSync = nhsync_q;
  assign o_nVSync = nvsync_q;
  assign o_HBlank = hblank_q;
  assign o_VBlank = vblank_q;

endmodule

// File: tb/tb_sync_to_blanking_gen.sv
// Testbench for sync_to_blanking_gen: reset/pass-through vector table,
// VGA-style horizontal and vertical sequences, and randomized sync streams
// compared against an event-timestamp reference model.
module tb_sync_to_blanking_gen;

  localparam int HFP  = 16;
  localparam int HBP  = 48;
  localparam int VFP  = 10;
  localparam int VBP  = 33;
  localparam int CW   = 12;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic nh  = 1'b1;
  logic nv  = 1'b1;
  logic o_nh, o_nv, o_hb, o_vb;

  always #5 clk = ~clk;

  sync_to_blanking_gen dut (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_nHSync (nh),
    .i_nVSync (nv),
    .o_nHSync (o_nh),
    .o_nVSync (o_nv),
    .o_HBlank (o_hb),
    .o_VBlank (o_vb)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: positions derived from sample timestamps and event counts
  int n = 0;
  int h_anchor = 0, hf_count = 0, v_mark = 0;
  bit prev_h = 1'b1, prev_v = 1'b1;
  int m_L = 0, m_W = 0, m_T = 0, m_VW = 0;
  int h_first_rise = -1, h_last_fall = -1;
  int v_first_rise = -1, v_last_fall = -1;
  int m_p = 0, m_v = 0;
  bit exp_nh = 1'b1, exp_nv = 1'b1, exp_hb = 1'b1, exp_vb = 1'b1;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input bit r, input bit h, input bit v);
    bit hfall, hrise, vfall, vrise, hlock, vlock;
    int prev_p, prev_vi;
    n++;
    if (r) begin
      h_anchor = n; hf_count = 0; v_mark = 0;
      prev_h = 1'b1; prev_v = 1'b1;
      m_L = 0; m_W = 0; m_T = 0; m_VW = 0;
      h_first_rise = -1; h_last_fall = -1;
      v_first_rise = -1; v_last_fall = -1;
      m_p = 0; m_v = 0;
      exp_nh = 1'b1; exp_nv = 1'b1; exp_hb = 1'b1; exp_vb = 1'b1;
      return;
    end
    hfall = prev_h && !h;
    hrise = !prev_h && h;
    vfall = prev_v && !v;
    vrise = !prev_v && v;
    prev_p  = imin(n - 1 - h_anchor, CMAX);
    prev_vi = imin(hf_count - v_mark, CMAX);
    if (hfall) begin
      m_L = prev_p + 1;
      h_anchor = n;
      h_last_fall = n;
      hf_count++;
    end
    m_p = imin(n - h_anchor, CMAX);
    if (hrise) begin
      m_W = m_p;
      if (h_first_rise < 0) h_first_rise = n;
    end
    if (vfall) begin
      m_T = prev_vi + 1;
      v_mark = hf_count;
      v_last_fall = n;
    end
    m_v = imin(hf_count - v_mark, CMAX);
    if (vrise) begin
      m_VW = m_v;
      if (v_first_rise < 0) v_first_rise = n;
    end
    hlock = (h_first_rise >= 0) && (h_last_fall > h_first_rise);
    vlock = (v_first_rise >= 0) && (v_last_fall > v_first_rise);
    exp_hb = !hlock || (m_p < m_W + HBP) || (m_p + HFP >= m_L);
    exp_vb = !vlock || (m_v < m_VW + VBP) || (m_v + VFP >= m_T);
    exp_nh = h;
    exp_nv = v;
    prev_h = h;
    prev_v = v;
  endtask

  // Drive one sample on the falling edge, let the DUT take it, then step the model
  task automatic cycle(input bit r, input bit h, input bit v);
    @(negedge clk);
    rst = r; nh = h; nv = v;
    @(posedge clk);
    #1;
    model_step(r, h, v);
  endtask

  task automatic check_out(input string name, input logic [3:0] expv);
    logic [3:0] act;
    act = {o_nh, o_nv, o_hb, o_vb};
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s sample %0d: got {nH,nV,HB,VB}=%b expected %b", name, n, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // One line: hsync low for the first hsw samples, vsync level held for the line
  task automatic run_line(input int len, input int hsw, input bit vlow, input int rst_at,
                          output int act_cnt, output int first, output int last,
                          output bit vb_mid);
    act_cnt = 0; first = -1; last = -1; vb_mid = 1'b1;
    for (int i = 0; i < len; i++) begin
      cycle(i == rst_at, i >= hsw, !vlow);
      check_out("model", {exp_nh, exp_nv, exp_hb, exp_vb});
      if (!o_hb) begin
        act_cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (i == len / 2) vb_mid = o_vb;
    end
  endtask

  typedef struct {
    bit         r;
    bit         h;
    bit         v;
    logic [3:0] expv;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cnt, fst, lst, vcnt, vfst, vlst, nlines;
    bit vbm;

    // Reset hold, release, then pass-through before any lock
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b1111};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 4'b1111};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'b1111};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 4'b1111};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b1111};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 4'b1111};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'b0111};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b0011};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 4'b1111};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b1011};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 4'b0111};
    for (int i = 0; i < 12; i++) begin
      cycle(vecs[i].r, vecs[i].h, vecs[i].v);
      check_out("vector", vecs[i].expv);
    end

    // VGA horizontal: 800-clock line, 96-clock hsync
    cycle(1'b1, 1'b1, 1'b1);
    check_out("reset", 4'b1111);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b1);
      check_out("idle", 4'b1111);
    end
    run_line(800, 96, 1'b0, -1, cnt, fst, lst, vbm);
    check_int("h_unlocked_active", cnt, 0);
    for (int k = 0; k < 2; k++) begin
      run_line(800, 96, 1'b0, -1, cnt, fst, lst, vbm);
      check_int("h800_active_cnt", cnt, 640);
      check_int("h800_first", fst, 144);
      check_int("h800_last", lst, 783);
    end
    // Switch to 1000-clock lines: old length governs the first one
    run_line(1000, 96, 1'b0, -1, cnt, fst, lst, vbm);
    check_int("h1000_first_line_last", lst, 783);
    run_line(1000, 96, 1'b0, -1, cnt, fst, lst, vbm);
    check_int("h1000_first", fst, 144);
    check_int("h1000_last", lst, 983);
    check_int("h1000_active_cnt", cnt, 840);
    // Mid-line reset during active video
    run_line(1000, 96, 1'b0, 500, cnt, fst, lst, vbm);
    check_int("rst_line_last", lst, 499);
    run_line(1000, 96, 1'b0, -1, cnt, fst, lst, vbm);
    check_int("relock_line_active", cnt, 0);
    run_line(1000, 96, 1'b0, -1, cnt, fst, lst, vbm);
    check_int("relocked_active_cnt", cnt, 840);
    check_int("relocked_first", fst, 144);

    // VGA vertical: 525-line frames, 2-line vsync, short lines to keep runtime low
    cycle(1'b1, 1'b1, 1'b1);
    check_out("reset_v", 4'b1111);
    for (int f = 0; f < 2; f++) begin
      vcnt = 0; vfst = -1; vlst = -1;
      for (int ln = 0; ln < 525; ln++) begin
        run_line(24, 4, ln < 2, -1, cnt, fst, lst, vbm);
        if (!vbm) begin
          vcnt++;
          if (vfst < 0) vfst = ln;
          vlst = ln;
        end
      end
      if (f == 0) begin
        check_int("v_first_frame_active", vcnt, 0);
      end else begin
        check_int("v_active_lines", vcnt, 480);
        check_int("v_first_active", vfst, 35);
        check_int("v_last_active", vlst, 514);
      end
    end

    // Randomized: raw bit noise
    cycle(1'b1, 1'b1, 1'b1);
    check_out("reset_r", 4'b1111);
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) == 0, 1'($urandom), 1'($urandom));
      check_out("rand_bits", {exp_nh, exp_nv, exp_hb, exp_vb});
    end
    // Randomized: frames of random-length lines with occasional reset
    for (int f = 0; f < 3; f++) begin
      nlines = $urandom_range(45, 70);
      for (int ln = 0; ln < nlines; ln++) begin
        int len;
        len = $urandom_range(60, 160);
        run_line(len, $urandom_range(1, 40), ln < 2,
                 ($urandom_range(0, 149) == 0) ? $urandom_range(0, len - 1) : -1,
                 cnt, fst, lst, vbm);
      end
    end
    // Overlong line drives the pixel counter into saturation
    run_line(4300, 96, 1'b0, -1, cnt, fst, lst, vbm);
    run_line(800, 96, 1'b0, -1, cnt, fst, lst, vbm);
    run_line(800, 96, 1'b0, -1, cnt, fst, lst, vbm);
    check_int("post_sat_active_cnt", cnt, 640);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
